instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameters: NB_DATA, 32, data/instruction/PC width; NB_ADDR, 8, instruction-memory word-index width (256 words).
REQ-002 SHALL have ports, one per line:
- clk  in  1  pipeline clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_stall  in  1  hazard hold of PC and IF/ID register
- i_jump  in  1  jump redirect request
- i_jump_addr  in  NB_DATA  jump target, byte address
- i_branch_taken  in  1  branch redirect request
- i_branch_addr  in  NB_DATA  branch target, byte address
- i_load_en  in  1  program-load write strobe
- i_load_addr  in  NB_ADDR  program-load word index
- i_load_data  in  NB_DATA  program-load word
- i_start  in  1  begin execution
- i_clear  in  1  abort or return to idle
- i_step_mode  in  1  single-step enable
- i_step  in  1  single-step advance pulse
- o_instruction  out  NB_DATA  IF/ID instruction to decode
- o_pcounter4  out  NB_DATA  IF/ID PC+4 to decode
- o_pc  out  NB_DATA  current fetch PC
- o_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  HALTED state indicator

Function
REQ-003 SHALL implement FSM states IDLE, RUN, HALTED; reset state IDLE.
REQ-004 IDLE: PC held at 0; IF/ID outputs NOP (32'h0), o_valid=0; i_load_en writes imem[i_load_addr] <= i_load_data at clock edge.
REQ-005 i_load_en SHALL be ignored in RUN and HALTED.
REQ-006 IDLE -> RUN on i_start; first fetch from PC=0 on the cycle after entry.
REQ-007 Instruction read SHALL be combinational from imem[PC[NB_ADDR+1:2]]; PC bits above the index are ignored (wrap-around); PC[1:0] ignored.
REQ-008 RUN advance condition: not i_stall, and (i_step_mode=0 or i_step=1).
REQ-009 Each RUN cycle priority: i_clear > i_stall/step-hold > i_jump > i_branch_taken > HALT detect > sequential.
REQ-010 Advance, no redirect: PC <= PC+4; IF/ID <= {imem word, PC+4}; o_valid <= 1. Latency: instruction at PC visible on o_instruction one cycle after o_pc=PC.
REQ-011 Hold (stall or step not pulsed): PC, IF/ID, o_valid unchanged; redirect requests during hold are ignored.
REQ-012 Redirect: PC <= target; IF/ID flushed to NOP, o_pcounter4 <= 0, o_valid <= 0; jump wins over branch when both assert.
REQ-013 HALT word 32'hFFFFFFFF fetched with advance and no redirect: latched into IF/ID with o_valid=1; PC stays; next state HALTED.
REQ-014 Redirect in same cycle as HALT fetch: redirect wins, HALT discarded, state stays RUN.
REQ-015 HALTED: PC frozen; IF/ID <= NOP, o_valid=0 from the first HALTED cycle; o_halted=1; i_start, i_stall, redirects ignored.
REQ-016 i_clear in RUN or HALTED: next state IDLE, PC <= 0, IF/ID NOP, o_valid=0; i_clear in IDLE has no effect; imem contents preserved.
REQ-017 PC addition SHALL be NB_DATA-bit modulo; 32'hFFFFFFFC+4 = 0.
REQ-018 o_pc SHALL reflect the PC register directly (no pipeline delay).

Reset
REQ-019 Reset SHALL drive state IDLE, PC 0, o_instruction 0, o_pcounter4 0, o_valid 0, o_halted 0, asynchronously, regardless of state or pending requests.
REQ-020 imem contents SHALL NOT be reset; reset mid-RUN requires reload or reuses existing contents.
REQ-021 First clock edge after reset release SHALL behave as IDLE.

Structure
REQ-022 Shared package SHALL hold: NOP word 32'h0, HALT word 32'hFFFFFFFF, state encodings, PC increment 4.
REQ-023 One sub-module instruction_memory (write port, combinational read port, NB_DATA x 2^NB_ADDR); FSM, PC and IF/ID register in instruction_fetch.

Verification
REQ-024 Load imem[0..2]={32'h20010005,32'h20020003,32'hFFFFFFFF}, i_start -> o_instruction shows the three words on consecutive cycles with o_pcounter4=4,8,12, then o_halted=1, o_valid=0.
REQ-025 Stall high 3 cycles while PC=8 -> o_pc stays 8, IF/ID unchanged 3 cycles, resume at 8.
REQ-026 i_jump=1 with target 32'h40 and i_branch_taken=1 with target 32'h80 same cycle -> next o_pc=32'h40, o_valid=0, o_instruction=0.
REQ-027 i_step_mode=1, i_step pulsed twice 4 cycles apart -> PC advances exactly 2 words.
REQ-028 Redirect coinciding with HALT fetch -> no HALTED entry; i_clear in HALTED -> IDLE, PC=0, i_load_en accepted.
REQ-029 i_rst_n low mid-RUN at PC=32'h1C -> outputs zero immediately, state IDLE; imem readback unchanged.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Instruction-memory port bundle: one synchronous write port and one
// combinational read port.
interface instruction_fetch_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);

  logic               we;
  logic [NB_ADDR-1:0] waddr;
  logic [NB_DATA-1:0] wdata;
  logic [NB_ADDR-1:0] raddr;
  logic [NB_DATA-1:0] rdata;

  modport master (output we, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input we, input waddr, input wdata, input raddr, output rdata);

endinterface : instruction_fetch_if

// File: rtl/instruction_memory.sv
// Program store: NB_DATA x 2^NB_ADDR words, clocked write, combinational read.
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                clk,
  instruction_fetch_if.slave  mem
);

  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

  // NOTE: storage has no reset on purpose; program contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (mem.we) mem_q[mem.waddr] <= mem.wdata;
  end

  assign mem.rdata = mem_q[mem.raddr];

endmodule : instruction_memory

// File: rtl/instruction_fetch.sv
// Fetch stage: IDLE/RUN/HALTED control, program counter and IF/ID register
// in front of a loadable instruction memory.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic               i_load_en,
  input  logic [NB_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  input  logic               i_start,
  input  logic               i_clear,
  input  logic               i_step_mode,
  input  logic               i_step,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_valid,
  output logic               o_halted
);

  localparam logic [NB_DATA-1:0] NOP  = NB_DATA'(NOP_WORD);
  localparam logic [NB_DATA-1:0] HALT = NB_DATA'(HALT_WORD);
  localparam logic [NB_DATA-1:0] INC  = NB_DATA'(PC_INC);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] fetch_word;
  logic               advance;

  instruction_fetch_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) imem_bus ();

  instruction_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_imem (
    .clk (clk),
    .mem (imem_bus.slave)
  );

  // Loads are only honoured while idle so a running program cannot be overwritten.
  assign imem_bus.we    = i_load_en && (state_q == ST_IDLE);
  assign imem_bus.waddr = i_load_addr;
  assign imem_bus.wdata = i_load_data;
  assign imem_bus.raddr = pc_q[NB_ADDR+1:2];
  assign fetch_word     = imem_bus.rdata;

  assign pc_plus4 = pc_q + INC;
  assign advance  = !i_stall && (!i_step_mode || i_step);

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d    = '0;
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_clear) begin
          state_d = ST_IDLE;
          pc_d    = '0;
          instr_d = NOP;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (advance) begin
          if (i_jump || i_branch_taken) begin
            pc_d    = i_jump ? i_jump_addr : i_branch_addr;
            instr_d = NOP;
            pc4_d   = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = fetch_word;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            // A HALT word parks the PC on itself and stops fetching.
            if (fetch_word == HALT) state_d = ST_HALTED;
            else                    pc_d    = pc_plus4;
          end
        end
      end
      ST_HALTED: begin
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
        if (i_clear) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign halted_d = (state_d == ST_HALTED);

  // NOTE: state flops use non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_valid       = valid_q;
  assign o_halted      = halted_q;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed and randomized bench for instruction_fetch with a behavioural
// reference model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, branch, start, clear, step_mode, step;
  logic [31:0] jump_addr, branch_addr;
  logic [31:0] o_instruction, o_pcounter4, o_pc;
  logic        o_valid, o_halted;

  instruction_fetch_if #(.NB_DATA(32), .NB_ADDR(8)) lb ();
  assign lb.raddr = '0;
  assign lb.rdata = '0;

  instruction_fetch #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clk            (clk),
    .i_rst_n        (rst_n),
    .i_stall        (stall),
    .i_jump         (jump),
    .i_jump_addr    (jump_addr),
    .i_branch_taken (branch),
    .i_branch_addr  (branch_addr),
    .i_load_en      (lb.we),
    .i_load_addr    (lb.waddr),
    .i_load_data    (lb.wdata),
    .i_start        (start),
    .i_clear        (clear),
    .i_step_mode    (step_mode),
    .i_step         (step),
    .o_instruction  (o_instruction),
    .o_pcounter4    (o_pcounter4),
    .o_pc           (o_pc),
    .o_valid        (o_valid),
    .o_halted       (o_halted)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_mem [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_flush();
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  // Applies one clock edge's worth of the fetch rules to the model.
  task automatic model_next();
    logic [31:0] w;
    if (m_mode == 0) begin
      if (lb.we) m_mem[lb.waddr] = lb.wdata;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (clear) begin
        model_reset();
      end else if (stall || (step_mode && !step)) begin
        // hold
      end else if (jump) begin
        m_pc = jump_addr; model_flush();
      end else if (branch) begin
        m_pc = branch_addr; model_flush();
      end else begin
        w       = m_mem[(m_pc / 4) % 256];
        m_instr = w;
        m_pc4   = m_pc + 4;
        m_valid = 1;
        if (w == HALT) m_mode = 2;
        else           m_pc = m_pc + 4;
      end
    end else begin
      if (clear) model_reset();
      else       model_flush();
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"},    o_pc,          m_pc);
    check({tag, ".instr"}, o_instruction, m_instr);
    check({tag, ".pc4"},   o_pcounter4,   m_pc4);
    check({tag, ".valid"}, 32'(o_valid),  32'(m_valid));
    check({tag, ".halt"},  32'(o_halted), 32'(m_mode == 2));
  endtask

  task automatic tick(input string tag);
    model_next();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    stall = 0; jump = 0; branch = 0; start = 0; clear = 0;
    step_mode = 0; step = 0; jump_addr = 0; branch_addr = 0;
    lb.we = 0; lb.waddr = 0; lb.wdata = 0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0000_0013;
    return w;
  endfunction

  task automatic load(input logic [7:0] a, input logic [31:0] d, input string tag);
    lb.we = 1; lb.waddr = a; lb.wdata = d;
    tick(tag);
    lb.we = 0;
  endtask

  logic [31:0] pc_ref;

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // Program image: random non-HALT filler, then the three-word program.
    for (int i = 0; i < 256; i++) load(8'(i), rand_word(), "fill");
    load(8'd0, 32'h2001_0005, "load0");
    load(8'd1, 32'h2002_0003, "load1");
    load(8'd2, HALT,          "load2");
    check("idle_pc", o_pc, 32'h0);

    start = 1; tick("start"); start = 0;
    check("run_pc0", o_pc, 32'h0);
    tick("f0");
    check("f0_instr", o_instruction, 32'h2001_0005);
    check("f0_pc4",   o_pcounter4,   32'd4);
    tick("f1");
    check("f1_instr", o_instruction, 32'h2002_0003);
    check("f1_pc4",   o_pcounter4,   32'd8);
    tick("f2");
    check("f2_instr", o_instruction, HALT);
    check("f2_pc4",   o_pcounter4,   32'd12);
    check("f2_halt",  32'(o_halted), 32'd1);
    tick("h0");
    check("h0_valid", 32'(o_valid),  32'd0);
    check("h0_pc",    o_pc,          32'd8);

    // Everything but clear is ignored once halted.
    start = 1; stall = 1; jump = 1; jump_addr = 32'h40;
    lb.we = 1; lb.waddr = 8'd9; lb.wdata = 32'h1234_5678;
    tick("h_ignore");
    idle_inputs();
    check("h_ignore_pc", o_pc, 32'd8);
    clear = 1; tick("h_clear"); clear = 0;
    check("clr_pc",   o_pc,          32'd0);
    check("clr_halt", 32'(o_halted), 32'd0);
    load(8'd2, 32'h0000_0013, "reload2");

    // Stall while PC=8.
    start = 1; tick("s_start"); start = 0;
    tick("s_a0"); tick("s_a1");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_pc",  o_pc,        32'd8);
      check("stall_pc4", o_pcounter4, 32'd8);
    end
    stall = 0;
    tick("resume");
    check("resume_pc", o_pc, 32'd12);

    // Jump beats branch.
    jump = 1; jump_addr = 32'h40; branch = 1; branch_addr = 32'h80;
    tick("jb");
    jump = 0; branch = 0;
    check("jb_pc",    o_pc,          32'h40);
    check("jb_valid", 32'(o_valid),  32'd0);
    check("jb_instr", o_instruction, 32'h0);

    // Single-step: two pulses four cycles apart.
    step_mode = 1;
    pc_ref = m_pc;
    for (int i = 0; i < 10; i++) begin
      step = (i == 1 || i == 5);
      tick("step");
    end
    step = 0; step_mode = 0;
    check("step_pc", o_pc, pc_ref + 32'd8);

    // Redirect in the same cycle as a HALT fetch.
    clear = 1; tick("c1"); clear = 0;
    load(8'd5, HALT, "load5");
    start = 1; tick("r_start"); start = 0;
    for (int i = 0; i < 5; i++) tick("r_adv");
    check("r_pc", o_pc, 32'h14);
    branch = 1; branch_addr = 32'h100; tick("r_redir"); branch = 0;
    check("r_halt", 32'(o_halted), 32'd0);
    check("r_pc2",  o_pc,          32'h100);
    tick("r_after");
    clear = 1; tick("c2"); clear = 0;
    load(8'd5, rand_word(), "restore5");

    // PC wrap-around.
    start = 1; tick("w_start"); start = 0;
    jump = 1; jump_addr = 32'hFFFF_FFFC; tick("w_jump"); jump = 0;
    tick("w_adv");
    check("wrap_pc",    o_pc,        32'h0);
    check("wrap_pc4",   o_pcounter4, 32'h0);
    check("wrap_instr", o_instruction, m_mem[255]);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      clear       = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      jump        = ($urandom_range(0, 15) == 0);
      branch      = ($urandom_range(0, 7) == 0);
      jump_addr   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63)) << 2;
      branch_addr = 32'($urandom_range(0, 63)) << 2;
      step_mode   = ($urandom_range(0, 7) == 0);
      step        = $urandom_range(0, 1) == 1;
      lb.we       = $urandom_range(0, 1) == 1;
      lb.waddr    = 8'($urandom_range(0, 63));
      lb.wdata    = ($urandom_range(0, 7) == 0) ? HALT : rand_word();
      tick("rand");
    end
    idle_inputs();

    // Asynchronous reset mid-run at PC=0x1C.
    clear = 1; tick("c3"); clear = 0;
    for (int i = 0; i < 8; i++) load(8'(i), rand_word(), "reload");
    start = 1; tick("x_start"); start = 0;
    for (int i = 0; i < 7; i++) tick("x_adv");
    check("x_pc", o_pc, 32'h1C);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("arst_pc",    o_pc,          32'h0);
    check("arst_instr", o_instruction, 32'h0);
    check("arst_pc4",   o_pcounter4,   32'h0);
    check("arst_valid", 32'(o_valid),  32'd0);
    check_outputs("arst");
    @(negedge clk);
    rst_n = 1;
    tick("post_rst_idle");
    start = 1; tick("rb_start"); start = 0;
    for (int i = 0; i < 10; i++) tick("readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instruction_fetch
